// File: rtl/read_miss_issuer_pkg.sv
// rtl/read_miss_issuer_pkg.sv - shared widths, FIFO entry type and issue FSM encoding for the read-miss path
// Macros (overridable on the command line): AXI_ADDR_WIDTH, TID_WIDTH, AXI_ID_WIDTH.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef TID_WIDTH
`define TID_WIDTH 8
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

package read_miss_issuer_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = `AXI_ADDR_WIDTH;
    localparam int unsigned DEF_TID_WIDTH  = `TID_WIDTH;
    localparam int unsigned DEF_ID_WIDTH   = `AXI_ID_WIDTH;
    localparam int unsigned DEF_LINE_BYTES = 64;
    localparam int unsigned LINE_OFFSET    = $clog2(DEF_LINE_BYTES);

    // R_MISS_FIFO entry as seen by the fill handler; tid occupies the MSBs.
    typedef struct packed {
        logic [DEF_TID_WIDTH-1:0]  tid;
        logic [DEF_ADDR_WIDTH-1:0] addr;
    } r_miss_entry_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } issue_state_e;

endpackage

// File: rtl/read_miss_issuer_credit.sv
// rtl/read_miss_issuer_credit.sv - up/down in-flight miss counter with a below-limit flag
// Ports: clk, rst_n (sync, active-low), inc_i (+1), dec_i (-1, ignored at zero),
//        count_o (registered count), below_max_o (count_o < MAX_COUNT).
module miss_credit_counter #(
    parameter int unsigned MAX_COUNT = 8,
    parameter int unsigned CNT_WIDTH = $clog2(MAX_COUNT) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc_i,
    input  logic                 dec_i,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic                 below_max_o
);

    localparam logic [CNT_WIDTH-1:0] MAX_VAL = CNT_WIDTH'(MAX_COUNT);

    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 inc_ok, dec_ok;

    always_comb begin
        count_d = count_q;
        // Saturate at both ends so a stray pop cannot wrap the count.
        inc_ok  = inc_i && (count_q != MAX_VAL);
        dec_ok  = dec_i && (count_q != '0);
        if (inc_ok && !dec_ok) begin
            count_d = count_q + CNT_WIDTH'(1);
        end else if (dec_ok && !inc_ok) begin
            count_d = count_q - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o     = count_q;
    assign below_max_o = (count_q < MAX_VAL);

endmodule

// File: rtl/read_miss_issuer.sv
// rtl/read_miss_issuer.sv - accepts read misses, pushes {tid, line addr} into R_MISS_FIFO and issues one AXI AR per miss
// Ports: miss_* (miss request handshake), write_en_o/wdata_fifo_o/full_i (FIFO push side),
//        pop_i (fill side pop), ar* (AXI AR channel), outstanding_o (in-flight count).
// Optional macro READ_MISS_PERF_CNT_EN adds miss_cnt_o / stall_cnt_o saturating counters.
module read_miss_issuer
    import read_miss_issuer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int unsigned TID_WIDTH       = DEF_TID_WIDTH,
    parameter int unsigned ID_WIDTH        = DEF_ID_WIDTH,
    parameter int unsigned LINE_BYTES      = DEF_LINE_BYTES,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned CNT_WIDTH       = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          miss_valid_i,
    output logic                          miss_ready_o,
    input  logic [ADDR_WIDTH-1:0]         miss_addr_i,
    input  logic [TID_WIDTH-1:0]          miss_tid_i,
    output logic                          write_en_o,
    input  logic                          full_i,
    output logic [ADDR_WIDTH+TID_WIDTH-1:0] wdata_fifo_o,
    input  logic                          pop_i,
    output logic                          arvalid_o,
    input  logic                          arready_i,
    output logic [ADDR_WIDTH-1:0]         araddr_o,
    output logic [ID_WIDTH-1:0]           arid_o,
    output logic [CNT_WIDTH-1:0]          outstanding_o
`ifdef READ_MISS_PERF_CNT_EN
    ,
    output logic [31:0]                   miss_cnt_o,
    output logic [31:0]                   stall_cnt_o
`endif
);

    localparam int unsigned           OFF       = $clog2(LINE_BYTES);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~((ADDR_WIDTH'(1) << OFF) - ADDR_WIDTH'(1));

    issue_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [ID_WIDTH-1:0]   arid_q, arid_d;
    logic [ID_WIDTH-1:0]   id_cnt_q, id_cnt_d;
    logic [ADDR_WIDTH-1:0] aligned_addr;
    logic                  credit_ok;
    logic                  accept;

    assign aligned_addr = miss_addr_i & LINE_MASK;

    miss_credit_counter #(
        .MAX_COUNT (MAX_OUTSTANDING),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_credit (
        .clk         (clk),
        .rst_n       (rst_n),
        .inc_i       (accept),
        .dec_i       (pop_i),
        .count_o     (outstanding_o),
        .below_max_o (credit_ok)
    );

    always_comb begin
        state_d  = state_q;
        araddr_d = araddr_q;
        arid_d   = arid_q;
        id_cnt_d = id_cnt_q;
        // rst_n gates ready so nothing is accepted while the flops are being cleared.
        miss_ready_o = rst_n && (state_q == S_IDLE) && !full_i && credit_ok;
        accept       = miss_valid_i && miss_ready_o;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    araddr_d = aligned_addr;
                    arid_d   = id_cnt_q;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // AR registers are frozen here so the channel stays stable under backpressure.
                if (arready_i) begin
                    id_cnt_d = id_cnt_q + ID_WIDTH'(1);
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            araddr_q <= '0;
            arid_q   <= '0;
            id_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            araddr_q <= araddr_d;
            arid_q   <= arid_d;
            id_cnt_q <= id_cnt_d;
        end
    end

    assign write_en_o   = accept;
    assign wdata_fifo_o = {miss_tid_i, aligned_addr};
    assign arvalid_o    = (state_q == S_ISSUE);
    assign araddr_o     = araddr_q;
    assign arid_o       = arid_q;

`ifdef READ_MISS_PERF_CNT_EN
    logic [31:0] miss_cnt_q, miss_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        miss_cnt_d  = miss_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (accept && (miss_cnt_q != 32'hFFFF_FFFF)) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
        if (miss_valid_i && !miss_ready_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            miss_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            miss_cnt_q  <= miss_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign miss_cnt_o  = miss_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_read_miss_issuer.sv
// tb/tb_read_miss_issuer.sv - directed vector bench for read_miss_issuer
module tb_read_miss_issuer;
    import read_miss_issuer_pkg::*;

    localparam int AW = 32;
    localparam int TW = 8;
    localparam int IW = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          miss_valid_i = 1'b0;
    logic          miss_ready_o;
    logic [AW-1:0] miss_addr_i = '0;
    logic [TW-1:0] miss_tid_i = '0;
    logic          write_en_o;
    logic          full_i = 1'b0;
    logic [AW+TW-1:0] wdata_fifo_o;
    logic          pop_i = 1'b0;
    logic          arvalid_o;
    logic          arready_i = 1'b0;
    logic [AW-1:0] araddr_o;
    logic [IW-1:0] arid_o;
    logic [CW-1:0] outstanding_o;
`ifdef READ_MISS_PERF_CNT_EN
    logic [31:0]   miss_cnt_o;
    logic [31:0]   stall_cnt_o;
`endif

    always #5 clk = ~clk;

    read_miss_issuer #(
        .ADDR_WIDTH      (AW),
        .TID_WIDTH       (TW),
        .ID_WIDTH        (IW),
        .LINE_BYTES      (64),
        .MAX_OUTSTANDING (8),
        .CNT_WIDTH       (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .miss_valid_i  (miss_valid_i),
        .miss_ready_o  (miss_ready_o),
        .miss_addr_i   (miss_addr_i),
        .miss_tid_i    (miss_tid_i),
        .write_en_o    (write_en_o),
        .full_i        (full_i),
        .wdata_fifo_o  (wdata_fifo_o),
        .pop_i         (pop_i),
        .arvalid_o     (arvalid_o),
        .arready_i     (arready_i),
        .araddr_o      (araddr_o),
        .arid_o        (arid_o),
        .outstanding_o (outstanding_o)
`ifdef READ_MISS_PERF_CNT_EN
        ,
        .miss_cnt_o    (miss_cnt_o),
        .stall_cnt_o   (stall_cnt_o)
`endif
    );

    typedef struct {
        logic          rst_n;
        logic          mv;
        logic [AW-1:0] addr;
        logic [TW-1:0] tid;
        logic          full;
        logic          pop;
        logic          ard;
        logic          e_mr;
        logic          e_we;
        logic          e_av;
        logic [AW-1:0] e_ara;
        logic [IW-1:0] e_id;
        logic [CW-1:0] e_out;
    } vec_t;

    int pass_cnt = 0;
    int total_cnt = 0;
    int step_no = 0;

    function automatic vec_t mk(logic r, logic mv, logic [AW-1:0] a, logic [TW-1:0] t,
                                logic f, logic p, logic ard, logic mr, logic we, logic av,
                                logic [AW-1:0] ara, logic [IW-1:0] id, logic [CW-1:0] o);
        vec_t v;
        v.rst_n = r;   v.mv = mv;    v.addr = a;   v.tid = t;
        v.full = f;    v.pop = p;    v.ard = ard;
        v.e_mr = mr;   v.e_we = we;  v.e_av = av;
        v.e_ara = ara; v.e_id = id;  v.e_out = o;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL step %0d %s: got %h, expected %h", step_no, nm, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    // Drive one cycle of inputs after the falling edge, check outputs 2ns later.
    task automatic apply(input vec_t v);
        r_miss_entry_t exp_entry;
        @(negedge clk);
        rst_n        = v.rst_n;
        miss_valid_i = v.mv;
        miss_addr_i  = v.addr;
        miss_tid_i   = v.tid;
        full_i       = v.full;
        pop_i        = v.pop;
        arready_i    = v.ard;
        #2;
        exp_entry.tid  = v.tid;
        exp_entry.addr = v.addr & 32'hFFFF_FFC0;
        chk("miss_ready", 64'(miss_ready_o), 64'(v.e_mr));
        chk("write_en", 64'(write_en_o), 64'(v.e_we));
        chk("wdata_fifo", 64'(wdata_fifo_o), 64'(exp_entry));
        chk("arvalid", 64'(arvalid_o), 64'(v.e_av));
        chk("outstanding", 64'(outstanding_o), 64'(v.e_out));
        if (v.e_av) begin
            chk("araddr", 64'(araddr_o), 64'(v.e_ara));
            chk("arid", 64'(arid_o), 64'(v.e_id));
        end
        step_no++;
    endtask

    vec_t tbl[$];

    initial begin
        // reset, single miss, pops incl. underflow guard
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0, 1,0,0,0,0,0));
        tbl.push_back(mk(1,1,32'h1234_5678,8'd3,0,0,1, 1,1,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,1, 0,0,1,32'h1234_5640,4'd0,4'd1));
        tbl.push_back(mk(1,0,0,0,0,0,0, 1,0,0,0,0,1));
        tbl.push_back(mk(1,0,0,0,0,1,0, 1,0,0,0,0,1));
        tbl.push_back(mk(1,0,0,0,0,1,0, 1,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0, 1,0,0,0,0,0));
        // FIFO full blocks, accept on the cycle full drops, full during ISSUE harmless
        tbl.push_back(mk(1,1,32'hABCD_EF7F,8'h55,1,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(1,1,32'hABCD_EF7F,8'h55,1,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(1,1,32'hABCD_EF7F,8'h55,0,0,0, 1,1,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,1,0,1, 0,0,1,32'hABCD_EF40,4'd1,4'd1));
        tbl.push_back(mk(1,0,0,0,0,0,0, 1,0,0,0,0,1));
        // build up to 4 outstanding; miss_valid during ISSUE is held off
        tbl.push_back(mk(1,1,32'h100,8'd1,0,0,0, 1,1,0,0,0,1));
        tbl.push_back(mk(1,1,32'hDEAD_0000,8'hEE,0,0,1, 0,0,1,32'h100,4'd2,4'd2));
        tbl.push_back(mk(1,1,32'h2C0,8'd2,0,0,0, 1,1,0,0,0,2));
        tbl.push_back(mk(1,0,0,0,0,0,1, 0,0,1,32'h2C0,4'd3,4'd3));
        tbl.push_back(mk(1,1,32'h3FF,8'd4,0,0,0, 1,1,0,0,0,3));
        tbl.push_back(mk(1,0,0,0,0,0,1, 0,0,1,32'h3C0,4'd4,4'd4));
        // accept + pop together at 4 keeps 4
        tbl.push_back(mk(1,1,32'h1000,8'd9,0,1,0, 1,1,0,0,0,4));
        tbl.push_back(mk(1,0,0,0,0,0,1, 0,0,1,32'h1000,4'd5,4'd4));
        tbl.push_back(mk(1,0,0,0,0,0,0, 1,0,0,0,0,4));

        foreach (tbl[i]) apply(tbl[i]);

        // AR backpressure for 5 cycles with a new miss waiting
        apply(mk(1,1,32'h8000_0040,8'd7,0,0,0, 1,1,0,0,0,4));
        for (int k = 0; k < 5; k++)
            apply(mk(1,1,32'h8000_0080,8'd8,0,0,0, 0,0,1,32'h8000_0040,4'd6,4'd5));
        apply(mk(1,0,0,0,0,0,1, 0,0,1,32'h8000_0040,4'd6,4'd5));
        apply(mk(1,0,0,0,0,0,0, 1,0,0,0,0,5));
        apply(mk(1,1,32'h8000_0080,8'd8,0,0,0, 1,1,0,0,0,5));
        apply(mk(1,0,0,0,0,0,1, 0,0,1,32'h8000_0080,4'd7,4'd6));

        // credit limit at 8; pop re-enables acceptance one cycle later
        apply(mk(1,1,32'h40,8'd1,0,0,0, 1,1,0,0,0,6));
        apply(mk(1,0,0,0,0,0,1, 0,0,1,32'h40,4'd8,4'd7));
        apply(mk(1,1,32'h80,8'd2,0,0,0, 1,1,0,0,0,7));
        apply(mk(1,0,0,0,0,0,1, 0,0,1,32'h80,4'd9,4'd8));
        apply(mk(1,1,32'hC0,8'd3,0,0,0, 0,0,0,0,0,8));
        apply(mk(1,1,32'hC0,8'd3,0,1,0, 0,0,0,0,0,8));
        apply(mk(1,1,32'hC0,8'd3,0,0,0, 1,1,0,0,0,7));

        // reset while an AR is stalled
        apply(mk(1,0,0,0,0,0,0, 0,0,1,32'hC0,4'd10,4'd8));
        apply(mk(1,0,0,0,0,0,0, 0,0,1,32'hC0,4'd10,4'd8));
        apply(mk(0,0,0,0,0,0,0, 0,0,1,32'hC0,4'd10,4'd8));
        apply(mk(1,0,0,0,0,0,0, 1,0,0,0,0,0));
        apply(mk(1,1,32'h200,8'd5,0,0,0, 1,1,0,0,0,0));
        apply(mk(1,0,0,0,0,0,1, 0,0,1,32'h200,4'd0,4'd1));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
